plic_ctrl: RTL and testbench
============================

Name: plic_ctrl

Overview:
- Parametrised platform-level interrupt controller for the SoC; successor to the fixed 4-source pass-through PLIC.
- Adds per-source gateways, programmable priorities, an enable mask, a priority threshold, claim/complete handshake, and a single registered external-interrupt request to the core.
- Sits between the SoC irq pins and the riscv core's plic_irq input.
- Core/JTAG reach it through a simple single-cycle register port.

Parameters:
- SRC_NUM, 8, number of interrupt sources (1..31); irq_i[k] is source ID k+1; ID 0 means "none".
- PRIO_W, 3, priority field width; priority 0 = never interrupts.
- DW, 32, register data width.
- AW, 12, register offset width.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, synchronous, active-low
- irq_i  in  SRC_NUM  source requests, already synchronous to clk
- reg_we  in  1  register write strobe
- reg_re  in  1  register read strobe
- reg_addr  in  AW  byte offset, word aligned
- reg_wdata  in  DW  write data
- reg_rdata  out  DW  read data, valid the cycle after reg_re
- ext_irq_o  out  1  external interrupt request to core
- claim_id_o  out  5  current best candidate ID, debug/observability

Behaviour:
- Reset (rstn=0 at a clk edge) clears all of the following to 0: priorities, enable, threshold, pending, in_flight, reg_rdata, ext_irq_o, claim_id_o.
- Register map:
  - 0x000+4*(id-1): priority, RW, low PRIO_W bits.
  - 0x080: pending, RO; bit k = source k+1. Writes are ignored.
  - 0x100: enable, RW, SRC_NUM bits.
  - 0x200: threshold, RW, PRIO_W bits.
  - 0x204: claim/complete.
  - Unmapped reads return 0; unmapped writes are ignored.
- Gateway, level mode: pending[k] is set when irq_i[k]=1 and in_flight[k]=0. pending is cleared only by a claim.
- Arbiter candidate: pending & enable & (priority > threshold).
- Selection: highest priority wins; ties go to the lowest ID. Evaluated combinationally, then registered into claim_id_o, so there is 1 cycle latency.
- ext_irq_o = (claim_id_o != 0), registered. Net latency is 2 clk from an irq_i rise to ext_irq_o=1.
- Claim: reg_re at 0x204 returns the current claim_id_o on the next cycle's reg_rdata. In the same cycle it clears pending[id] and sets in_flight[id]. If no candidate exists, it returns 0 with no side effect.
- Complete: reg_we at 0x204 with wdata=id clears in_flight[id].
  - Ignored if id=0, id>SRC_NUM, or in_flight[id]=0.
  - A source still held high re-pends on the following cycle.
- Simultaneous events:
  - Claim and a new irq_i assertion of the same source in one cycle: the claim wins, and in_flight blocks the re-pend.
  - Complete and claim of different IDs in one cycle: both take effect.
  - Reg writes changing priority/enable/threshold affect arbitration from the next cycle.
- reg_we and reg_re both high is illegal; the write takes precedence and the read returns 0.
- Reset mid-handshake: all in_flight are dropped. Sources still asserted re-pend 1 cycle after rstn rises.

Optional Feature:
- PLIC_EDGE_TRIG_EN defined:
  - Adds a trigger-mode register at 0x0C0 (RW, SRC_NUM bits, 1=edge), reset 0.
  - Edge-mode gateways latch pending on a rising edge of irq_i (previous-sample register).
  - A rising edge that arrives while in_flight=1 is recorded in a single-deep "edge_seen" bit and becomes pending on complete.
- Undefined:
  - Level mode only.
  - Offset 0x0C0 reads 0 and writes are ignored.
  - No edge registers are synthesised.

Decomposition:
- Package plic_pkg holds:
  - register offset localparams (PRIO_BASE, PENDING_OFF, ENABLE_OFF, TRIG_OFF, THRESH_OFF, CLAIM_OFF);
  - ID width constant (5);
  - ID_NONE=0.
- One natural sub-module, plic_gateway, instantiated SRC_NUM times. It owns pending/in_flight/edge logic and takes claim/complete pulses.
- Arbiter and register file stay in plic_ctrl.

Test Plan:
- Reset then idle: irq_i=0 → reg_rdata, ext_irq_o, claim_id_o all 0; pending read at 0x080 = 0.
- Src3 priority 2, enable bit2, threshold 1; raise irq_i[2] at cycle t → claim_id_o=3 at t+1, ext_irq_o=1 at t+2. Claim read → 3; pending bit2 clears.
- Src2 and src5, both priority 4, raised together → claim returns 2. Complete 2, then claim → 5. Raise threshold to 4 → ext_irq_o drops, claim returns 0.
- Level src held high: claim 1, then complete 1 → re-pends next cycle. Complete 7 with src7 not in flight → no state change.
- Invalid complete wdata=0 and wdata=SRC_NUM+1 → ignored. Priority 0 source pending with enable set → never asserts ext_irq_o.
- With PLIC_EDGE_TRIG_EN: src4 edge-mode, two pulses while in flight → one extra pending after complete. Without the macro, 0x0C0 reads 0.

Source files
------------

// File: rtl/plic_pkg.sv
// Shared constants for the platform-level interrupt controller:
// register offsets, source-ID width and the "no interrupt" ID.
package plic_pkg;

  localparam int unsigned ID_W = 5;
  localparam logic [ID_W-1:0] ID_NONE = '0;

  localparam int unsigned PRIO_BASE   = 'h000;
  localparam int unsigned PENDING_OFF = 'h080;
  localparam int unsigned TRIG_OFF    = 'h0C0;
  localparam int unsigned ENABLE_OFF  = 'h100;
  localparam int unsigned THRESH_OFF  = 'h200;
  localparam int unsigned CLAIM_OFF   = 'h204;

endpackage

// File: rtl/plic_ctrl_if.sv
// Single-cycle register port of the PLIC. The core/JTAG side is the
// master; the controller is the slave. Read data follows reg_re by one cycle.
interface plic_ctrl_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic          reg_we;
  logic          reg_re;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata;

  modport master (output reg_we, reg_re, reg_addr, reg_wdata, input reg_rdata);
  modport slave  (input reg_we, reg_re, reg_addr, reg_wdata, output reg_rdata);
endinterface

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: owns the pending and in_flight flags and
// reacts to claim/complete pulses from the controller.
// With PLIC_EDGE_TRIG_EN defined, a source can be switched to edge mode;
// a rising edge seen while the source is in flight is remembered in a
// single-deep edge_seen bit and turns into pending on complete.
module plic_gateway (
  input  logic clk,
  input  logic rstn,
  input  logic irq,
  input  logic claim,
  input  logic complete,
`ifdef PLIC_EDGE_TRIG_EN
  input  logic edge_mode,
`endif
  output logic pending,
  output logic in_flight
);

`ifdef PLIC_EDGE_TRIG_EN
  logic irq_q;
  logic edge_seen;
  logic rise;

  assign rise = irq & ~irq_q;

  // Pending / in-flight tracking for level and edge sources.
  // NOTE: state is updated with <= so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      irq_q     <= 1'b0;
      edge_seen <= 1'b0;
      pending   <= 1'b0;
      in_flight <= 1'b0;
    end else begin
      irq_q <= irq;
      if (claim) begin
        pending   <= 1'b0;
        in_flight <= 1'b1;
        if (edge_mode && rise) edge_seen <= 1'b1;
      end else if (complete && in_flight) begin
        in_flight <= 1'b0;
        if (edge_mode) begin
          pending   <= edge_seen | rise;
          edge_seen <= 1'b0;
        end
      end else if (edge_mode) begin
        if (rise) begin
          if (in_flight) edge_seen <= 1'b1;
          else           pending   <= 1'b1;
        end
      end else if (irq && !in_flight) begin
        pending <= 1'b1;
      end
    end
  end
`else
  // Level-mode pending / in-flight tracking; claim beats a same-cycle request.
  // NOTE: state is updated with <= so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pending   <= 1'b0;
      in_flight <= 1'b0;
    end else begin
      if (claim) begin
        pending   <= 1'b0;
        in_flight <= 1'b1;
      end else begin
        if (complete) in_flight <= 1'b0;
        if (irq && !in_flight) pending <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/plic_ctrl.sv
// Platform-level interrupt controller: register file, gateways, priority
// arbiter and registered external interrupt request to the core.
// Optional feature macro: PLIC_EDGE_TRIG_EN adds the per-source trigger-mode
// register (edge/level); without it all sources are level-triggered.
module plic_ctrl
  import plic_pkg::*;
#(
  parameter int SRC_NUM = 8,
  parameter int PRIO_W  = 3,
  parameter int DW      = 32,
  parameter int AW      = 12
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [SRC_NUM-1:0] irq_i,
  plic_ctrl_if.slave         bus,
  output logic               ext_irq_o,
  output logic [ID_W-1:0]    claim_id_o
);

  logic [PRIO_W-1:0]  prio [SRC_NUM];
  logic [SRC_NUM-1:0] enable;
  logic [PRIO_W-1:0]  thresh;
`ifdef PLIC_EDGE_TRIG_EN
  logic [SRC_NUM-1:0] trig_mode;
`endif

  logic [SRC_NUM-1:0] pending;
  logic [SRC_NUM-1:0] in_flight;
  logic [SRC_NUM-1:0] cand;
  logic [SRC_NUM-1:0] claim_vec;
  logic [SRC_NUM-1:0] comp_vec;
  logic [ID_W-1:0]    best_id;
  logic [PRIO_W-1:0]  best_prio;
  logic [DW-1:0]      rd_mux;
  logic               rd_en;
  logic               claim_rd;
  logic               claim_hit;

  // A simultaneous write wins; the read then returns 0 and has no side effect.
  assign rd_en    = bus.reg_re & ~bus.reg_we;
  assign claim_rd = rd_en && (bus.reg_addr == AW'(CLAIM_OFF));

  // Candidates, claim/complete pulses and best-candidate selection.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    cand      = '0;
    claim_vec = '0;
    comp_vec  = '0;
    best_id   = ID_NONE;
    best_prio = '0;
    for (int k = 0; k < SRC_NUM; k++) begin
      cand[k]      = pending[k] & enable[k] & (prio[k] > thresh);
      // Only a still-valid candidate can be claimed; a stale ID claims nothing.
      claim_vec[k] = claim_rd && (claim_id_o == ID_W'(k + 1)) && cand[k];
      comp_vec[k]  = bus.reg_we && (bus.reg_addr == AW'(CLAIM_OFF)) &&
                     (bus.reg_wdata == DW'(k + 1));
      // Strict compare: on equal priority the lower ID is kept.
      if (cand[k] && (prio[k] > best_prio)) begin
        best_id   = ID_W'(k + 1);
        best_prio = prio[k];
      end
    end
  end

  assign claim_hit = |claim_vec;

  // Register read multiplexer; unmapped offsets read 0.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < SRC_NUM; k++)
      if (bus.reg_addr == AW'(PRIO_BASE + 4 * k)) rd_mux = DW'(prio[k]);
    if (bus.reg_addr == AW'(PENDING_OFF)) rd_mux = DW'(pending);
    if (bus.reg_addr == AW'(ENABLE_OFF))  rd_mux = DW'(enable);
    if (bus.reg_addr == AW'(THRESH_OFF))  rd_mux = DW'(thresh);
`ifdef PLIC_EDGE_TRIG_EN
    if (bus.reg_addr == AW'(TRIG_OFF))    rd_mux = DW'(trig_mode);
`endif
    if (bus.reg_addr == AW'(CLAIM_OFF))   rd_mux = DW'(claim_hit ? claim_id_o : ID_NONE);
  end

  // Register file writes and registered read data.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: the priority array is a handful of flops, so it is reset
      // explicitly rather than left to software like a RAM would be.
      for (int k = 0; k < SRC_NUM; k++) prio[k] <= '0;
      enable        <= '0;
      thresh        <= '0;
`ifdef PLIC_EDGE_TRIG_EN
      trig_mode     <= '0;
`endif
      bus.reg_rdata <= '0;
    end else begin
      bus.reg_rdata <= rd_en ? rd_mux : '0;
      if (bus.reg_we) begin
        for (int k = 0; k < SRC_NUM; k++)
          if (bus.reg_addr == AW'(PRIO_BASE + 4 * k)) prio[k] <= bus.reg_wdata[PRIO_W-1:0];
        if (bus.reg_addr == AW'(ENABLE_OFF)) enable <= bus.reg_wdata[SRC_NUM-1:0];
        if (bus.reg_addr == AW'(THRESH_OFF)) thresh <= bus.reg_wdata[PRIO_W-1:0];
`ifdef PLIC_EDGE_TRIG_EN
        if (bus.reg_addr == AW'(TRIG_OFF))   trig_mode <= bus.reg_wdata[SRC_NUM-1:0];
`endif
      end
    end
  end

  // Registered best candidate and the interrupt request derived from it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      claim_id_o <= ID_NONE;
      ext_irq_o  <= 1'b0;
    end else begin
      claim_id_o <= best_id;
      ext_irq_o  <= (claim_id_o != ID_NONE);
    end
  end

  for (genvar k = 0; k < SRC_NUM; k++) begin : g_gw
    plic_gateway u_gw (
      .clk       (clk),
      .rstn      (rstn),
      .irq       (irq_i[k]),
      .claim     (claim_vec[k]),
      .complete  (comp_vec[k]),
`ifdef PLIC_EDGE_TRIG_EN
      .edge_mode (trig_mode[k]),
`endif
      .pending   (pending[k]),
      .in_flight (in_flight[k])
    );
  end

endmodule

// File: tb/tb_plic_ctrl.sv
// Self-checking bench for plic_ctrl: register table, hand-written handshake
// sequences, and a randomized run against a behavioural model.
module tb_plic_ctrl;
  import plic_pkg::*;

  localparam int SRC_NUM = 8;
  localparam int PRIO_W  = 3;
  localparam int DW      = 32;
  localparam int AW      = 12;
  localparam logic [31:0] TRIG_RD =
`ifdef PLIC_EDGE_TRIG_EN
    32'hFF;
`else
    32'h0;
`endif

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [SRC_NUM-1:0] irq_i = '0;
  logic               ext_irq_o;
  logic [ID_W-1:0]    claim_id_o;

  plic_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  plic_ctrl #(.SRC_NUM(SRC_NUM), .PRIO_W(PRIO_W), .DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .irq_i      (irq_i),
    .bus        (bus),
    .ext_irq_o  (ext_irq_o),
    .claim_id_o (claim_id_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp;
  } vec_t;
  vec_t vt[17];

  // Behavioural model state.
  logic [SRC_NUM-1:0] m_pend, m_inf, m_en;
  logic [PRIO_W-1:0]  m_prio [SRC_NUM];
  logic [PRIO_W-1:0]  m_th;
  int                 m_cid;
  logic               m_ext;
  logic [31:0]        m_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    bus.reg_we = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
    cyc();
    bus.reg_we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
    bus.reg_re = 1'b1; bus.reg_addr = a;
    cyc();
    bus.reg_re = 1'b0;
    check(name, 64'(bus.reg_rdata), 64'(exp));
  endtask

  task automatic do_reset();
    irq_i = '0; bus.reg_we = 1'b0; bus.reg_re = 1'b0;
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
  endtask

  // Winner by the rules: scan priorities from the top, lowest ID first.
  function automatic int m_best();
    for (int p = (1 << PRIO_W) - 1; p > int'(m_th); p--)
      for (int id = 1; id <= SRC_NUM; id++)
        if (m_pend[id-1] && m_en[id-1] && int'(m_prio[id-1]) == p) return id;
    return 0;
  endfunction

  function automatic bit m_is_cand(input int id);
    if (id < 1 || id > SRC_NUM) return 1'b0;
    return m_pend[id-1] && m_en[id-1] && (m_prio[id-1] > m_th);
  endfunction

  task automatic model_step(input logic [SRC_NUM-1:0] irq, input logic we, input logic re,
                            input logic [AW-1:0] a, input logic [31:0] wd);
    logic [SRC_NUM-1:0] claimed, completed;
    int ret, best, ia;
    claimed = '0; completed = '0; ia = int'(a);
    best = m_best();
    ret = m_is_cand(m_cid) ? m_cid : 0;
    m_rdata = 32'h0;
    if (re && !we) begin
      if (ia < 4 * SRC_NUM)      m_rdata = 32'(m_prio[ia/4]);
      else if (ia == 'h080)      m_rdata = 32'(m_pend);
      else if (ia == 'h100)      m_rdata = 32'(m_en);
      else if (ia == 'h200)      m_rdata = 32'(m_th);
      else if (ia == 'h204)      m_rdata = 32'(ret);
      if (ia == 'h204 && ret != 0) claimed[ret-1] = 1'b1;
    end
    if (we && ia == 'h204 && wd >= 1 && wd <= SRC_NUM && m_inf[int'(wd)-1])
      completed[int'(wd)-1] = 1'b1;
    m_pend = ~claimed & (m_pend | (irq & ~m_inf));
    m_inf  = (m_inf | claimed) & ~completed;
    if (we) begin
      if (ia < 4 * SRC_NUM) m_prio[ia/4] = wd[PRIO_W-1:0];
      if (ia == 'h100)      m_en = wd[SRC_NUM-1:0];
      if (ia == 'h200)      m_th = wd[PRIO_W-1:0];
    end
    m_ext = (m_cid != 0);
    m_cid = best;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.reg_we = 1'b0; bus.reg_re = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;

    vt[0]  = '{1'b1, 1'b0, 12'h004, 32'd5,        32'd0};
    vt[1]  = '{1'b0, 1'b1, 12'h004, 32'd0,        32'd5};
    vt[2]  = '{1'b1, 1'b0, 12'h01C, 32'hFF,       32'd0};
    vt[3]  = '{1'b0, 1'b1, 12'h01C, 32'd0,        32'd7};
    vt[4]  = '{1'b1, 1'b0, 12'h100, 32'hFFFFFFFF, 32'd0};
    vt[5]  = '{1'b0, 1'b1, 12'h100, 32'd0,        32'hFF};
    vt[6]  = '{1'b1, 1'b0, 12'h200, 32'h1F,       32'd0};
    vt[7]  = '{1'b0, 1'b1, 12'h200, 32'd0,        32'd7};
    vt[8]  = '{1'b1, 1'b0, 12'h080, 32'hFF,       32'd0};
    vt[9]  = '{1'b0, 1'b1, 12'h080, 32'd0,        32'd0};
    vt[10] = '{1'b1, 1'b0, 12'h300, 32'h12345678, 32'd0};
    vt[11] = '{1'b0, 1'b1, 12'h300, 32'd0,        32'd0};
    vt[12] = '{1'b1, 1'b0, 12'h0C0, 32'hFF,       32'd0};
    vt[13] = '{1'b0, 1'b1, 12'h0C0, 32'd0,        TRIG_RD};
    vt[14] = '{1'b0, 1'b1, 12'h000, 32'd0,        32'd0};
    vt[15] = '{1'b1, 1'b0, 12'h020, 32'd3,        32'd0};
    vt[16] = '{1'b0, 1'b1, 12'h020, 32'd0,        32'd0};

    // Reset then idle.
    do_reset();
    check("rst_rdata", 64'(bus.reg_rdata), 64'd0);
    check("rst_ext", 64'(ext_irq_o), 64'd0);
    check("rst_cid", 64'(claim_id_o), 64'd0);
    rd_chk("rst_pending", 12'h080, 32'd0);

    // Register file table.
    for (int i = 0; i < 17; i++) begin
      bus.reg_we = vt[i].we; bus.reg_re = vt[i].re;
      bus.reg_addr = vt[i].addr; bus.reg_wdata = vt[i].wdata;
      cyc();
      bus.reg_we = 1'b0; bus.reg_re = 1'b0;
      if (vt[i].re) check($sformatf("reg_vec%0d", i), 64'(bus.reg_rdata), 64'(vt[i].exp));
    end

    // Latency and basic claim.
    do_reset();
    wr(12'h008, 2); wr(12'h100, 32'h04); wr(12'h200, 1);
    irq_i[2] = 1'b1;
    cyc();
    check("lat_cid_t", 64'(claim_id_o), 64'd0);
    cyc();
    check("lat_cid_t1", 64'(claim_id_o), 64'd3);
    check("lat_ext_t1", 64'(ext_irq_o), 64'd0);
    cyc();
    check("lat_ext_t2", 64'(ext_irq_o), 64'd1);
    irq_i[2] = 1'b0;
    rd_chk("claim3", 12'h204, 32'd3);
    rd_chk("pend_after_claim3", 12'h080, 32'd0);

    // Priority tie, complete/claim, threshold masking.
    do_reset();
    wr(12'h004, 4); wr(12'h010, 4); wr(12'h100, 32'h12); wr(12'h200, 1);
    irq_i = 8'h12;
    cyc();
    irq_i = '0;
    idle(2);
    rd_chk("tie_claim2", 12'h204, 32'd2);
    wr(12'h204, 2);
    rd_chk("claim5", 12'h204, 32'd5);
    wr(12'h204, 5);
    irq_i[4] = 1'b1;
    cyc();
    irq_i[4] = 1'b0;
    idle(2);
    check("ext_before_thresh", 64'(ext_irq_o), 64'd1);
    wr(12'h200, 4);
    idle(2);
    check("ext_after_thresh", 64'(ext_irq_o), 64'd0);
    rd_chk("claim_none", 12'h204, 32'd0);
    rd_chk("pend_kept", 12'h080, 32'h10);

    // Level source held high re-pends after complete; bogus complete.
    do_reset();
    wr(12'h000, 3); wr(12'h100, 32'h41);
    irq_i[0] = 1'b1;
    idle(3);
    rd_chk("lvl_claim1", 12'h204, 32'd1);
    rd_chk("lvl_inflight", 12'h080, 32'd0);
    wr(12'h204, 1);
    rd_chk("lvl_repend_t0", 12'h080, 32'd0);
    rd_chk("lvl_repend_t1", 12'h080, 32'd1);
    wr(12'h204, 7);
    rd_chk("cmp7_noeffect", 12'h080, 32'd1);
    idle(1);
    check("lvl_cid", 64'(claim_id_o), 64'd1);

    // Invalid completes and a priority-0 source.
    do_reset();
    wr(12'h000, 3); wr(12'h100, 32'h05);
    irq_i = 8'h05;
    idle(3);
    rd_chk("inv_claim1", 12'h204, 32'd1);
    wr(12'h204, 0);
    wr(12'h204, SRC_NUM + 1);
    idle(2);
    rd_chk("inv_pend", 12'h080, 32'h04);
    check("prio0_ext", 64'(ext_irq_o), 64'd0);
    wr(12'h204, 1);
    idle(3);
    check("inv_cid_after", 64'(claim_id_o), 64'd1);
    check("inv_ext_after", 64'(ext_irq_o), 64'd1);
    irq_i = '0;

    // Write and read in the same cycle.
    do_reset();
    bus.reg_we = 1'b1; bus.reg_re = 1'b1; bus.reg_addr = 12'h100; bus.reg_wdata = 32'h3;
    cyc();
    bus.reg_we = 1'b0; bus.reg_re = 1'b0;
    check("wr_rd_rdata", 64'(bus.reg_rdata), 64'd0);
    rd_chk("wr_rd_effect", 12'h100, 32'h3);

    // Reset mid-handshake.
    do_reset();
    wr(12'h000, 3); wr(12'h100, 1);
    irq_i[0] = 1'b1;
    idle(3);
    rd_chk("mid_claim1", 12'h204, 32'd1);
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    rd_chk("mid_rst_t0", 12'h080, 32'd0);
    rd_chk("mid_rst_t1", 12'h080, 32'd1);

`ifdef PLIC_EDGE_TRIG_EN
    // Edge source: two pulses while in flight give one pending on complete.
    do_reset();
    wr(12'h00C, 2); wr(12'h100, 32'h08); wr(12'h0C0, 32'h08);
    irq_i[3] = 1'b1; cyc(); irq_i[3] = 1'b0;
    idle(2);
    rd_chk("edge_claim4", 12'h204, 32'd4);
    for (int i = 0; i < 2; i++) begin
      irq_i[3] = 1'b1; cyc(); irq_i[3] = 1'b0; cyc();
    end
    rd_chk("edge_inflight", 12'h080, 32'd0);
    wr(12'h204, 4);
    rd_chk("edge_repend", 12'h080, 32'h08);
    idle(2);
    rd_chk("edge_claim4b", 12'h204, 32'd4);
    wr(12'h204, 4);
    idle(1);
    rd_chk("edge_single", 12'h080, 32'd0);
`endif

    // Randomized run against the model.
    do_reset();
    m_pend = '0; m_inf = '0; m_en = '0; m_th = '0; m_cid = 0; m_ext = 1'b0; m_rdata = '0;
    for (int k = 0; k < SRC_NUM; k++) m_prio[k] = '0;
    for (int n = 0; n < 3000; n++) begin
      logic [SRC_NUM-1:0] irq;
      logic               we, re;
      logic [AW-1:0]      a;
      logic [31:0]        wd;
      int                 op;
      logic [AW-1:0]      picks [7];
      picks = '{12'h000, 12'h004, 12'h100, 12'h200, 12'h0C0, 12'h300, 12'h080};
      irq = SRC_NUM'($urandom & $urandom & $urandom);
      op = $urandom_range(0, 9);
      we = 1'b0; re = 1'b0; a = '0; wd = '0;
      case (op)
        3: begin re = 1'b1; a = 12'h204; end
        4: begin we = 1'b1; a = 12'h204; wd = $urandom_range(0, SRC_NUM + 1); end
        5: begin we = 1'b1; a = AW'(4 * $urandom_range(0, SRC_NUM)); wd = $urandom; end
        6: begin we = 1'b1; a = 12'h100; wd = $urandom; end
        7: begin we = 1'b1; a = 12'h200; wd = $urandom_range(0, 3); end
        8: begin re = 1'b1; a = 12'h080; end
        9: begin re = 1'b1; a = picks[$urandom_range(0, 6)]; end
        default: ;
      endcase
      irq_i = irq;
      bus.reg_we = we; bus.reg_re = re; bus.reg_addr = a; bus.reg_wdata = wd;
      model_step(irq, we, re, a, wd);
      cyc();
      check($sformatf("rand%0d{rdata,ext,cid}", n),
            {26'd0, bus.reg_rdata, ext_irq_o, claim_id_o},
            {26'd0, m_rdata, m_ext, 5'(m_cid)});
    end
    bus.reg_we = 1'b0; bus.reg_re = 1'b0; irq_i = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
